// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sequencer: opcodes, flag positions,
// sequencer states and the fixed flag pattern reported on a rejected request.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_SUMA  = 4'd0,
    OP_RESTA = 4'd1,
    OP_MULT  = 4'd2,
    OP_DIV   = 4'd3,
    OP_MOD   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9
  } op_e;

  localparam logic [3:0] OP_ULTIMO = 4'd9;

  localparam int BAND_N = 3;
  localparam int BAND_Z = 2;
  localparam int BAND_C = 1;
  localparam int BAND_V = 0;

  // A rejected request reports only Z set, as if the result were zero.
  localparam logic [3:0] BANDERAS_ERROR = 4'(1 << BAND_Z);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ESPERA,
    ST_RESPONDE
  } estado_e;

endpackage

// File: rtl/alu_secuenciador_if.sv
// Request, ALU and response signals of the sequencer. The slave side is the
// sequencer itself; the master side is whoever issues requests and hosts the ALU.
interface alu_secuenciador_if #(
    parameter int ANCHO = 3
);

    logic             sol_valido;
    logic             sol_listo;
    logic [ANCHO:0]   sol_a;
    logic [ANCHO:0]   sol_b;
    logic [3:0]       sol_op;

    logic [ANCHO:0]   alu_a;
    logic [ANCHO:0]   alu_b;
    logic [3:0]       alu_sel;
    logic [ANCHO:0]   alu_resultado;
    logic [3:0]       alu_banderas;

    logic             resp_valido;
    logic             resp_listo;
    logic [ANCHO:0]   resp_resultado;
    logic [3:0]       resp_banderas;
    logic             resp_error;

    logic             ocupado;

    modport slave (
        input  sol_valido, sol_a, sol_b, sol_op,
        input  alu_resultado, alu_banderas,
        input  resp_listo,
        output sol_listo,
        output alu_a, alu_b, alu_sel,
        output resp_valido, resp_resultado, resp_banderas, resp_error,
        output ocupado
    );

    modport master (
        output sol_valido, sol_a, sol_b, sol_op,
        output alu_resultado, alu_banderas,
        output resp_listo,
        input  sol_listo,
        input  alu_a, alu_b, alu_sel,
        input  resp_valido, resp_resultado, resp_banderas, resp_error,
        input  ocupado
    );

endinterface

// File: rtl/alu_valida_op.sv
// Decides whether a request can be sent to the ALU: the opcode must exist and
// division/modulo must not have a zero divisor.
module alu_valida_op
    import alu_pkg::*;
#(
    parameter int ANCHO = 3
) (
    input  logic [3:0]     op,
    input  logic [ANCHO:0] b,
    output logic           error
);

    logic op_ilegal;
    logic div_cero;

    assign op_ilegal = (op > OP_ULTIMO);
    assign div_cero  = ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
    assign error     = op_ilegal || div_cero;

endmodule

// File: rtl/alu_secuenciador.sv
// Accepts one ALU request, holds the ALU inputs for ESPERA settle cycles, then
// captures result and flags and offers them on the response port.
module alu_secuenciador
    import alu_pkg::*;
#(
    parameter int ANCHO  = 3,
    parameter int ESPERA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_secuenciador_if.slave bus
);

    localparam logic [3:0] CNT_INICIO = 4'(ESPERA - 1);

    estado_e    estado;
    logic [3:0] cnt;
    logic       error_sol;

    alu_valida_op #(
        .ANCHO (ANCHO)
    ) u_valida_op (
        .op    (bus.sol_op),
        .b     (bus.sol_b),
        .error (error_sol)
    );

    // NOTE: every register here is a small control/data flop, so all of them are
    // cleared by the async reset; outputs read 0 until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado             <= ST_IDLE;
            cnt                <= '0;
            bus.sol_listo      <= 1'b0;
            bus.alu_a          <= '0;
            bus.alu_b          <= '0;
            bus.alu_sel        <= '0;
            bus.resp_valido    <= 1'b0;
            bus.resp_resultado <= '0;
            bus.resp_banderas  <= '0;
            bus.resp_error     <= 1'b0;
            bus.ocupado        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this
            // block based on the values from before the edge.
            case (estado)
                ST_IDLE: begin
                    if (bus.sol_valido && bus.sol_listo) begin
                        bus.sol_listo <= 1'b0;
                        bus.ocupado   <= 1'b1;
                        if (error_sol) begin
                            bus.resp_resultado <= '0;
                            bus.resp_banderas  <= BANDERAS_ERROR;
                            bus.resp_error     <= 1'b1;
                            estado             <= ST_RESPONDE;
                        end else begin
                            bus.alu_a   <= bus.sol_a;
                            bus.alu_b   <= bus.sol_b;
                            bus.alu_sel <= bus.sol_op;
                            cnt         <= CNT_INICIO;
                            estado      <= ST_ESPERA;
                        end
                    end else begin
                        bus.sol_listo <= 1'b1;
                    end
                end

                ST_ESPERA: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.resp_resultado <= bus.alu_resultado;
                        bus.resp_banderas  <= bus.alu_banderas;
                        bus.resp_error     <= 1'b0;
                        bus.resp_valido    <= 1'b1;
                        estado             <= ST_RESPONDE;
                    end
                end

                ST_RESPONDE: begin
                    // An error response enters here with valid low; it rises one
                    // cycle later, matching the latency of a single-cycle ALU op.
                    if (bus.resp_valido && bus.resp_listo) begin
                        bus.resp_valido <= 1'b0;
                        bus.alu_a       <= '0;
                        bus.alu_b       <= '0;
                        bus.alu_sel     <= '0;
                        bus.sol_listo   <= 1'b1;
                        bus.ocupado     <= 1'b0;
                        estado          <= ST_IDLE;
                    end else begin
                        bus.resp_valido <= 1'b1;
                    end
                end

                default: estado <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_secuenciador.sv
// Directed bench for alu_secuenciador: one instance with a single settle cycle
// and one with three, each driving a behavioural ALU.
module tb_alu_secuenciador;

    logic clk;
    logic rst_n;

    int n_vec = 0;
    int n_err = 0;

    alu_secuenciador_if #(.ANCHO(3)) bus1 ();
    alu_secuenciador_if #(.ANCHO(3)) bus3 ();

    alu_secuenciador #(.ANCHO(3), .ESPERA(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    alu_secuenciador #(.ANCHO(3), .ESPERA(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {N,Z,C,V, result}; C/V meaningful for add/sub only.
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] sel);
        logic [4:0] w;
        logic [3:0] r;
        logic       c;
        logic       v;
        w = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (sel)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[3:0];
                c = w[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[3:0];
                c = w[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2: r = 4'(a * b);
            4'd3: r = (b != 4'd0) ? (a / b) : 4'd0;
            4'd4: r = (b != 4'd0) ? (a % b) : 4'd0;
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = a << b;
            4'd9: r = a >> b;
            default: r = 4'd0;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    always_comb {bus1.alu_banderas, bus1.alu_resultado} = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
    always_comb {bus3.alu_banderas, bus3.alu_resultado} = alu_model(bus3.alu_a, bus3.alu_b, bus3.alu_sel);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction on the ESPERA=1 instance, with an optional response stall
    // during which a competing request is offered.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                          input logic [3:0] exp_res, input logic [3:0] exp_band,
                          input logic exp_err, input int exp_lat, input int stall,
                          input string name);
        int         lat;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [3:0] exp_sel;
        exp_a   = exp_err ? 4'd0 : a;
        exp_b   = exp_err ? 4'd0 : b;
        exp_sel = exp_err ? 4'd0 : op;

        @(negedge clk);
        for (int i = 0; i < 20 && bus1.sol_listo !== 1'b1; i++) @(negedge clk);
        n_vec++;
        if (bus1.sol_listo !== 1'b1) begin
            n_err++;
            $display("FAIL %s sol_listo before request: got %b want 1", name, bus1.sol_listo);
        end
        bus1.sol_valido = 1'b1;
        bus1.sol_a      = a;
        bus1.sol_b      = b;
        bus1.sol_op     = op;
        @(negedge clk);
        bus1.sol_valido = 1'b0;

        lat = 0;
        while (bus1.resp_valido !== 1'b1 && lat < 40) begin
            n_vec++;
            if (bus1.alu_sel !== exp_sel || bus1.alu_a !== exp_a || bus1.alu_b !== exp_b) begin
                n_err++;
                $display("FAIL %s alu drive: got a=%0d b=%0d sel=%0d want a=%0d b=%0d sel=%0d",
                         name, bus1.alu_a, bus1.alu_b, bus1.alu_sel, exp_a, exp_b, exp_sel);
            end
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end

        for (int s = 0; s <= stall; s++) begin
            n_vec++;
            if (bus1.resp_valido !== 1'b1 || bus1.resp_resultado !== exp_res ||
                bus1.resp_banderas !== exp_band || bus1.resp_error !== exp_err) begin
                n_err++;
                $display("FAIL %s response: got v=%b res=%0d band=%b err=%b want v=1 res=%0d band=%b err=%b",
                         name, bus1.resp_valido, bus1.resp_resultado, bus1.resp_banderas,
                         bus1.resp_error, exp_res, exp_band, exp_err);
            end
            n_vec++;
            if (bus1.sol_listo !== 1'b0 || bus1.ocupado !== 1'b1 || bus1.alu_sel !== exp_sel) begin
                n_err++;
                $display("FAIL %s busy state: got listo=%b ocupado=%b sel=%0d want 0 1 %0d",
                         name, bus1.sol_listo, bus1.ocupado, bus1.alu_sel, exp_sel);
            end
            if (s < stall) begin
                bus1.sol_valido = 1'b1;
                bus1.sol_a      = 4'd7;
                bus1.sol_b      = 4'd1;
                bus1.sol_op     = 4'd0;
                @(negedge clk);
            end
        end

        bus1.sol_valido = 1'b0;
        bus1.resp_listo = 1'b1;
        @(negedge clk);
        bus1.resp_listo = 1'b0;
        n_vec++;
        if (bus1.resp_valido !== 1'b0 || bus1.sol_listo !== 1'b1 || bus1.ocupado !== 1'b0 ||
            bus1.alu_sel !== 4'd0 || bus1.alu_a !== 4'd0) begin
            n_err++;
            $display("FAIL %s return to idle: got v=%b listo=%b ocupado=%b sel=%0d a=%0d want 0 1 0 0 0",
                     name, bus1.resp_valido, bus1.sol_listo, bus1.ocupado, bus1.alu_sel, bus1.alu_a);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_vec++;
        if (bus1.sol_listo !== 1'b0 || bus1.resp_valido !== 1'b0 || bus1.ocupado !== 1'b0 ||
            bus1.alu_sel !== 4'd0 || bus1.resp_resultado !== 4'd0 || bus1.resp_error !== 1'b0 ||
            bus1.resp_banderas !== 4'd0 || bus1.alu_a !== 4'd0 || bus1.alu_b !== 4'd0) begin
            n_err++;
            $display("FAIL reset outputs: got listo=%b v=%b ocupado=%b sel=%0d res=%0d want all 0",
                     bus1.sol_listo, bus1.resp_valido, bus1.ocupado, bus1.alu_sel, bus1.resp_resultado);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if (bus1.sol_listo !== 1'b0) begin
            n_err++;
            $display("FAIL reset release sol_listo: got %b want 0", bus1.sol_listo);
        end
        @(negedge clk);
        n_vec++;
        if (bus1.sol_listo !== 1'b1 || bus1.ocupado !== 1'b0 || bus3.sol_listo !== 1'b1) begin
            n_err++;
            $display("FAIL after release: got listo=%b ocupado=%b listo3=%b want 1 0 1",
                     bus1.sol_listo, bus1.ocupado, bus3.sol_listo);
        end
    endtask

    task automatic test_legal_ops;
        run_op(4'd3,  4'd4, 4'd0, 4'd7,  4'b0000, 1'b0, 1, 0, "suma_3_4");
        run_op(4'd9,  4'd9, 4'd0, 4'd2,  4'b0011, 1'b0, 1, 0, "suma_carry_ovf");
        run_op(4'd3,  4'd5, 4'd1, 4'd14, 4'b1010, 1'b0, 1, 0, "resta_neg");
        run_op(4'd13, 4'd4, 4'd3, 4'd3,  4'b0000, 1'b0, 1, 0, "div_13_4");
        run_op(4'd12, 4'd2, 4'd9, 4'd3,  4'b0000, 1'b0, 1, 0, "shr_ultimo_op");
    endtask

    task automatic test_errors;
        run_op(4'd9, 4'd0, 4'd3,  4'd0, 4'b0100, 1'b1, 1, 0, "div_cero");
        run_op(4'd7, 4'd0, 4'd4,  4'd0, 4'b0100, 1'b1, 1, 0, "mod_cero");
        run_op(4'd1, 4'd1, 4'hC,  4'd0, 4'b0100, 1'b1, 1, 0, "op_C");
        run_op(4'd1, 4'd1, 4'd10, 4'd0, 4'b0100, 1'b1, 1, 0, "op_10");
    endtask

    task automatic test_stall;
        run_op(4'd2, 4'd2, 4'd1, 4'd0, 4'b0100, 1'b0, 1, 5, "stall_resta");
    endtask

    task automatic test_idle_resp_listo;
        bus1.resp_listo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus1.resp_valido !== 1'b0 || bus1.sol_listo !== 1'b1 || bus1.ocupado !== 1'b0) begin
                n_err++;
                $display("FAIL idle resp_listo: got v=%b listo=%b ocupado=%b want 0 1 0",
                         bus1.resp_valido, bus1.sol_listo, bus1.ocupado);
            end
        end
        bus1.resp_listo = 1'b0;
    endtask

    task automatic test_espera3;
        int lat;
        @(negedge clk);
        bus3.sol_valido = 1'b1;
        bus3.sol_a      = 4'd5;
        bus3.sol_b      = 4'd3;
        bus3.sol_op     = 4'd2;
        @(negedge clk);
        bus3.sol_valido = 1'b0;
        lat = 0;
        while (bus3.resp_valido !== 1'b1 && lat < 40) begin
            n_vec++;
            if (bus3.alu_sel !== 4'd2 || bus3.alu_a !== 4'd5 || bus3.alu_b !== 4'd3) begin
                n_err++;
                $display("FAIL espera3 alu hold: got a=%0d b=%0d sel=%0d want 5 3 2",
                         bus3.alu_a, bus3.alu_b, bus3.alu_sel);
            end
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL espera3 latency: got %0d want 3", lat);
        end
        n_vec++;
        if (bus3.resp_resultado !== 4'd15 || bus3.resp_banderas !== 4'b1000 || bus3.resp_error !== 1'b0) begin
            n_err++;
            $display("FAIL espera3 response: got res=%0d band=%b err=%b want 15 1000 0",
                     bus3.resp_resultado, bus3.resp_banderas, bus3.resp_error);
        end
        bus3.resp_listo = 1'b1;
        @(negedge clk);
        bus3.resp_listo = 1'b0;
        n_vec++;
        if (bus3.sol_listo !== 1'b1 || bus3.resp_valido !== 1'b0 || bus3.alu_sel !== 4'd0) begin
            n_err++;
            $display("FAIL espera3 idle: got listo=%b v=%b sel=%0d want 1 0 0",
                     bus3.sol_listo, bus3.resp_valido, bus3.alu_sel);
        end
    endtask

    task automatic test_reset_mid_op;
        logic seen;
        @(negedge clk);
        bus3.sol_valido = 1'b1;
        bus3.sol_a      = 4'd5;
        bus3.sol_b      = 4'd3;
        bus3.sol_op     = 4'd2;
        @(negedge clk);
        bus3.sol_valido = 1'b0;
        n_vec++;
        if (bus3.ocupado !== 1'b1 || bus3.alu_sel !== 4'd2) begin
            n_err++;
            $display("FAIL midop accept: got ocupado=%b sel=%0d want 1 2", bus3.ocupado, bus3.alu_sel);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus3.ocupado !== 1'b0 || bus3.alu_sel !== 4'd0 || bus3.alu_a !== 4'd0 ||
            bus3.sol_listo !== 1'b0 || bus3.resp_valido !== 1'b0) begin
            n_err++;
            $display("FAIL midop reset: got ocupado=%b sel=%0d a=%0d listo=%b v=%b want all 0",
                     bus3.ocupado, bus3.alu_sel, bus3.alu_a, bus3.sol_listo, bus3.resp_valido);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus3.resp_valido !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midop stray response: got resp_valido seen=%b want 0", seen);
        end
        n_vec++;
        if (bus3.sol_listo !== 1'b1 || bus3.ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL midop after release: got listo=%b ocupado=%b want 1 0",
                     bus3.sol_listo, bus3.ocupado);
        end
    endtask

    task automatic test_back_to_back;
        run_op(4'd6, 4'd3, 4'd7, 4'd5,  4'b0000, 1'b0, 1, 0, "xor_b2b");
        run_op(4'd3, 4'd2, 4'd8, 4'd12, 4'b1000, 1'b0, 1, 0, "shl_b2b");
    endtask

    initial begin
        rst_n           = 1'b0;
        bus1.sol_valido = 1'b0;
        bus1.sol_a      = '0;
        bus1.sol_b      = '0;
        bus1.sol_op     = '0;
        bus1.resp_listo = 1'b0;
        bus3.sol_valido = 1'b0;
        bus3.sol_a      = '0;
        bus3.sol_b      = '0;
        bus3.sol_op     = '0;
        bus3.resp_listo = 1'b0;

        test_reset();
        test_legal_ops();
        test_errors();
        test_stall();
        test_idle_resp_listo();
        test_espera3();
        test_reset_mid_op();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
